// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile write path: geometry, requester limit and
// the write-request record used by the arbiter, its bench and the hazard unit.
package regfile_pkg;

    localparam int AW       = 5;
    localparam int DW       = 32;
    localparam int NREQ_MAX = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_req_t;

    // True when at least two bits are set: clearing the lowest set bit leaves something.
    function automatic logic multi_hot(input logic [NREQ_MAX-1:0] v);
        return (v & (v - NREQ_MAX'(1))) != '0;
    endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Rotate-priority encoder: one-hot grant to the lowest requesting index at or
// above ptr, wrapping to the lowest requesting index overall.
module rr_prio_enc #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any
);

    logic [N-1:0] w_mask;
    logic [N-1:0] w_hi;
    logic [N-1:0] w_sel;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mask
            localparam logic [PW-1:0] IDX = PW'(gi);
            assign w_mask[gi] = (IDX >= ptr);
        end
    endgenerate

    // Requests at or above ptr win; otherwise fall back to the wrapped set.
    assign w_hi  = req & w_mask;
    assign w_sel = (w_hi != '0) ? w_hi : req;
    assign gnt   = w_sel & (~w_sel + N'(1));
    assign any   = (req != '0);

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the regfile write port among NREQ writeback
// requesters, with a registered write stage, pending-write mask and contention counter.
module regfile_wr_arbiter
    import regfile_pkg::NREQ_MAX;
    import regfile_pkg::multi_hot;
#(
    parameter int NREQ = 2,
    parameter int AW   = regfile_pkg::AW,
    parameter int DW   = regfile_pkg::DW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0][AW-1:0]    req_addr,
    input  logic [NREQ-1:0][DW-1:0]    req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       We3,
    output logic [AW-1:0]              Wa3,
    output logic [DW-1:0]              Wd3,
    output logic [(1<<AW)-1:0]         pend,
    output logic [15:0]                conflict_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   r_ptr;
    logic            r_we;
    logic [AW-1:0]   r_wa;
    logic [DW-1:0]   r_wd;
    logic [15:0]     r_cnt;

    logic [NREQ-1:0] w_gnt;
    logic            w_any;
    logic            w_multi;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;
    logic [PW-1:0]   w_gnt_idx;
    logic [PW-1:0]   w_ptr_next;

    rr_prio_enc #(
        .N  (NREQ),
        .PW (PW)
    ) u_enc (
        .req (req_valid),
        .ptr (r_ptr),
        .gnt (w_gnt),
        .any (w_any)
    );

    assign req_ready = w_gnt;
    assign w_multi   = multi_hot(NREQ_MAX'(req_valid));

    // Grant is one-hot, so an OR of the masked requests selects the winner.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        w_gnt_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_addr = w_sel_addr | req_addr[i];
                w_sel_data = w_sel_data | req_data[i];
                w_gnt_idx  = PW'(i);
            end
        end
    end

    assign w_ptr_next = (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + PW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
            r_we  <= 1'b0;
            r_wa  <= '0;
            r_wd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_any) begin
                r_ptr <= w_ptr_next;
                // x0 is hardwired: the grant is consumed but no write is issued.
                r_we  <= (w_sel_addr != '0);
                r_wa  <= w_sel_addr;
                r_wd  <= w_sel_data;
            end else begin
                r_we  <= 1'b0;
            end
            if (w_multi && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < (1 << AW); gi++) begin : g_pend
            assign pend[gi] = r_we && (r_wa == AW'(gi));
        end
    endgenerate

    assign We3          = r_we;
    assign Wa3          = r_wa;
    assign Wd3          = r_wd;
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: a behavioural grant/write model is
// compared every falling edge, with literal spot checks pinning the model.
module tb_regfile_wr_arbiter;
    import regfile_pkg::*;

    localparam int N = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [N-1:0]         req_valid;
    wr_req_t              rq [N];
    logic [N-1:0][AW-1:0] req_addr;
    logic [N-1:0][DW-1:0] req_data;
    logic [N-1:0]         req_ready;
    logic                 We3;
    logic [AW-1:0]        Wa3;
    logic [DW-1:0]        Wd3;
    logic [(1<<AW)-1:0]   pend;
    logic [15:0]          conflict_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i] = rq[i].addr;
            req_data[i] = rq[i].data;
        end
    end

    regfile_wr_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .We3          (We3),
        .Wa3          (Wa3),
        .Wd3          (Wd3),
        .pend         (pend),
        .conflict_cnt (conflict_cnt)
    );

    // Stand-in regfile with no x0 guard, so a stray x0 write would be visible.
    logic [DW-1:0] tb_rf [1<<AW];
    always @(posedge clk) begin
        if (We3) tb_rf[Wa3] <= Wd3;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: round-robin pointer, output stage, contention count.
    int            m_ptr;
    logic          m_we;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    int            m_cnt;

    function automatic int model_grant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ptr <= 0;
            m_we  <= 1'b0;
            m_wa  <= '0;
            m_wd  <= '0;
            m_cnt <= 0;
        end else begin
            int g;
            g = model_grant(req_valid, m_ptr);
            if (g >= 0) begin
                m_we  <= (rq[g].addr != 0);
                m_wa  <= rq[g].addr;
                m_wd  <= rq[g].data;
                m_ptr <= (g + 1) % N;
            end else begin
                m_we  <= 1'b0;
            end
            if ($countones(req_valid) >= 2 && m_cnt < 65535) m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_ready;
        g = model_grant(req_valid, m_ptr);
        exp_ready = (g >= 0) ? (N'(1) << g) : '0;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("We3", 64'(We3), 64'(m_we));
        check("Wa3", 64'(Wa3), 64'(m_wa));
        check("Wd3", 64'(Wd3), 64'(m_wd));
        check("pend", 64'(pend), m_we ? (64'd1 << m_wa) : 64'd0);
        check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) tb_rf[i] = '0;
        req_valid = '0;
        rq[0] = '0;
        rq[1] = '0;

        step();
        step();
        check("rst_We3", 64'(We3), 64'd0);
        check("rst_Wa3", 64'(Wa3), 64'd0);
        check("rst_Wd3", 64'(Wd3), 64'd0);
        check("rst_pend", 64'(pend), 64'd0);
        check("rst_cnt", 64'(conflict_cnt), 64'd0);
        reset = 1'b1;

        // Single requester, write to r5
        rq[0] = '{addr: 5'd5, data: 32'hDEADBEEF};
        req_valid = 2'b01;
        #1;
        check("single_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = 2'b00;
        check("single_We3", 64'(We3), 64'd1);
        check("single_Wa3", 64'(Wa3), 64'd5);
        check("single_Wd3", 64'(Wd3), 64'hDEADBEEF);
        check("single_pend", 64'(pend), 64'h20);
        step();
        check("single_rf5", 64'(tb_rf[5]), 64'hDEADBEEF);

        // x0 write from req1 (ptr is 1 here)
        rq[1] = '{addr: 5'd0, data: 32'hFFFFFFFF};
        req_valid = 2'b10;
        #1;
        check("x0_ready", 64'(req_ready), 64'h2);
        step();
        req_valid = 2'b00;
        check("x0_We3", 64'(We3), 64'd0);
        check("x0_pend", 64'(pend), 64'd0);
        step();
        check("x0_rf0", 64'(tb_rf[0]), 64'd0);

        // Contention from ptr=0: grants alternate 0,1,0,1
        rq[0] = '{addr: 5'd1, data: 32'hA0A0A0A0};
        rq[1] = '{addr: 5'd2, data: 32'hB1B1B1B1};
        req_valid = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("cont_ready", 64'(req_ready), (c % 2 == 0) ? 64'h1 : 64'h2);
            step();
        end
        req_valid = 2'b00;
        check("cont_cnt", 64'(conflict_cnt), 64'd4);
        check("cont_last_Wa3", 64'(Wa3), 64'd2);

        // Same address from both requesters, later grant must win
        rq[0] = '{addr: 5'd7, data: 32'h11111111};
        rq[1] = '{addr: 5'd7, data: 32'h22222222};
        req_valid = 2'b11;
        #1;
        check("same_ready0", 64'(req_ready), 64'h1);
        step();
        req_valid = 2'b10;
        check("same_Wd3_first", 64'(Wd3), 64'h11111111);
        #1;
        check("same_ready1", 64'(req_ready), 64'h2);
        step();
        req_valid = 2'b00;
        check("same_Wd3_second", 64'(Wd3), 64'h22222222);
        step();
        check("same_rf7", 64'(tb_rf[7]), 64'h22222222);
        check("same_cnt", 64'(conflict_cnt), 64'd5);

        // Reset asserted mid-cycle while a write sits in the output stage
        rq[0] = '{addr: 5'd3, data: 32'h33333333};
        req_valid = 2'b01;
        step();
        check("mid_We3_before", 64'(We3), 64'd1);
        rq[1] = '{addr: 5'd9, data: 32'h99999999};
        req_valid = 2'b10;
        #2;
        reset = 1'b0;
        #1;
        check("mid_We3", 64'(We3), 64'd0);
        check("mid_pend", 64'(pend), 64'd0);
        check("mid_cnt", 64'(conflict_cnt), 64'd0);
        check("mid_ready", 64'(req_ready), 64'h2);
        step();
        check("mid_held_We3", 64'(We3), 64'd0);
        #2;
        reset = 1'b1;
        step();
        req_valid = 2'b00;
        check("rel_We3", 64'(We3), 64'd1);
        check("rel_Wa3", 64'(Wa3), 64'd9);
        check("rel_Wd3", 64'(Wd3), 64'h99999999);
        step();
        check("rel_rf3_untouched", 64'(tb_rf[3]), 64'd0);

        // Counter saturation
        rq[0] = '{addr: 5'd4, data: 32'h44444444};
        rq[1] = '{addr: 5'd6, data: 32'h66666666};
        req_valid = 2'b11;
        repeat (65540) @(posedge clk);
        #1;
        req_valid = 2'b00;
        check("sat_cnt", 64'(conflict_cnt), 64'hFFFF);
        step();
        check("sat_hold", 64'(conflict_cnt), 64'hFFFF);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Shares the single write port (`We3`/`Wa3`/`Wd3`) of the 32x32 `regfile` among `NREQ` independent writeback requesters, such as ALU writeback and load writeback. Arbitration is round-robin with a valid/ready handshake per requester, and the granted write is registered once before it drives the regfile. The block also exports a pending-write mask so read-side hazard logic can see writes still in flight, plus a saturating contention counter for lab performance reporting.

## Interface
- `NREQ`, 2: number of write requesters (2..4).
- `AW`, 5: register address width; 2**AW registers.
- `DW`, 32: data width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  requester i has a write to offer.
- `req_addr`  in  NREQ x AW  destination register per requester.
- `req_data`  in  NREQ x DW  write data per requester.
- `req_ready`  out  NREQ  one-hot or zero; requester i's write is accepted this cycle.
- `We3`  out  1  regfile write enable (registered).
- `Wa3`  out  AW  regfile write address (registered).
- `Wd3`  out  DW  regfile write data (registered).
- `pend`  out  2**AW  bit k is 1 while a write to register k sits in the output stage.
- `conflict_cnt`  out  16  saturating count of cycles in which two or more `req_valid` bits were high.

## Operation
- **Handshake:** a transfer occurs for requester i when `req_valid[i] && req_ready[i]` at a rising edge.
  - `req_ready` is combinational from `req_valid` and `ptr`.
  - Requesters hold `addr` and `data` stable until accepted.
  - The arbiter never withdraws `ready` while `valid` is held.
- **Grant rule:** grant goes to the lowest index j ≥ `ptr` (wrapping modulo NREQ) with `req_valid[j]=1`. If no requester is valid, there is no grant and `req_ready` is all zero.
  - At most one grant is issued per cycle.
  - The output stage is always free, so a grant is issued every cycle that any requester is valid. There is no backpressure from the regfile.
- **Pointer update:** on a grant to j, `ptr` becomes (j+1) mod NREQ. With no grant, `ptr` holds. A continuously valid requester waits at most NREQ-1 cycles.
- **Output stage:** on a grant, `Wa3`/`Wd3` load the granted addr/data.
  - `We3` loads 1, except when `addr==0`: register x0 is hardwired, so `We3` loads 0. The x0 request still consumes its grant and advances `ptr`.
  - With no grant, `We3` loads 0 and `Wa3`/`Wd3` hold their previous values.
- **`pend`:** decoded combinationally from the output registers; `pend = We3 ? (1<<Wa3) : 0`.
- **Same-address writes** from different requesters are serialized in grant order, so the later grant's data is what finally sits in the regfile.
- **`conflict_cnt`:** increments by 1 at each edge where popcount(`req_valid`) ≥ 2. It saturates at 16'hFFFF.
- **Reset** (asynchronous, any time, including mid-stream): `ptr`=0, `We3`=0, `Wa3`=0, `Wd3`=0, `conflict_cnt`=0, hence `pend`=0.
  - `req_ready` follows combinationally from `req_valid` with `ptr`=0, but nothing is captured while `reset`=0.
  - Any write in the output stage is dropped; no partial write reaches the regfile after reset asserts.

## Timing
- Accept at edge N: `We3`/`Wa3`/`Wd3` are valid during cycle N→N+1, and the regfile writes at edge N+1. Latency is 1 cycle from acceptance to regfile update.
- Maximum throughput is one write per cycle across all requesters.
- A requester valid alone gets `req_ready`=1 in the same cycle, independent of `ptr`.
- The critical path is `req_valid` → rotate-priority encode → `req_ready` (combinational) and → output registers.
- Reset release: the first capture happens at the first rising edge with `reset`=1.

## Structure
- Shared package `regfile_pkg`: `AW`, `DW`, `NREQ_MAX`=4, and a `wr_req_t` struct {addr, data}. The testbench and the hazard unit use the same package.
- One sub-module, `rr_prio_enc`: parameterized rotate-priority encoder. Inputs are `req` and `ptr`; outputs are the one-hot `gnt` and `any`.
- The top level holds the `ptr`, output, and counter registers plus the `pend` decode.

## Test plan
- **Single requester:** reset, then req0 valid with addr=5, data=32'hDEADBEEF for 1 cycle → `req_ready`=01 that cycle; next cycle `We3`=1, `Wa3`=5, `Wd3`=DEADBEEF, `pend`=1<<5; regfile `Rd1` reads DEADBEEF from Ra1=5 afterwards.
- **Contention:** both valid continuously, req0 addr=1, req1 addr=2 → grants alternate 0,1,0,1 starting from `ptr`=0; `conflict_cnt` increments every cycle both are valid.
- **Same address:** req0 (addr 7, 32'h1111_1111) and req1 (addr 7, 32'h2222_2222) both valid → two writes in consecutive cycles; final regfile[7]=32'h2222_2222.
- **x0 write:** req1 addr=0, data=32'hFFFF_FFFF → `req_ready[1]`=1, next cycle `We3`=0, `pend`=0, `ptr` advances to 0; regfile[0] reads 0.
- **Reset mid-stream:** assert `reset`=0 between edges while `We3`=1 → `We3`, `pend`, and `conflict_cnt` go to 0 immediately; after release, req1 alone is granted on the first edge.
- **Saturation:** force both valid for 65540 cycles → `conflict_cnt` = 16'hFFFF and does not wrap.
